matrix_link_ctrl: RTL and testbench

- Host-side counterpart of the RISC-V matrix core wrapper on the DE2 board. Sits between the UART byte stream and the core's word-load/readback port.
- Input phase: packs incoming UART bytes into 32-bit operand words and loads N_IN of them with one-cycle ready pulses.
- Wait phase: waits for the core to raise and then drop busy.
- Output phase: steps the core's readback index N_OUT times, serialising each result word back to UART as bytes.

---
 rtl/matrix_link_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_matrix_link_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_link_ctrl.sv
// Host-side link controller. It packs UART bytes into operand words for the matrix core,
// waits for the job to finish, then streams the result words back out as bytes.
module matrix_link_ctrl #(
  parameter int unsigned N_IN    = 8,
  parameter int unsigned N_OUT   = 4,
  parameter int unsigned BUSY_TO = 16
) (
  input  logic        i_Clk,
  input  logic        i_Rstn,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic [31:0] o_word,
  output logic        o_word_ready,
  input  logic        i_core_busy,
  input  logic [31:0] i_core_result,
  output logic [2:0]  o_state,
  output logic        o_rx_drop,
  output logic        o_timeout
);

  localparam int unsigned WcW = $clog2(N_IN + 1);
  localparam int unsigned ToW = $clog2(BUSY_TO + 1);
  localparam int unsigned RcW = $clog2(N_OUT + 1);

  localparam logic [WcW-1:0] LastWord = WcW'(N_IN - 1);
  localparam logic [ToW-1:0] LastWait = ToW'(BUSY_TO - 1);
  localparam logic [RcW-1:0] LastRes  = RcW'(N_OUT - 1);

  typedef enum logic [2:0] {
    StRx     = 3'd0,
    StWait   = 3'd1,
    StRun    = 3'd2,
    StSettle = 3'd3,
    StTx     = 3'd4,
    StStep   = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [WcW-1:0] word_cnt_q, word_cnt_d;
  logic [ToW-1:0] wait_cnt_q, wait_cnt_d;
  logic [RcW-1:0] res_cnt_q, res_cnt_d;
  logic           settle_q, settle_d;
  logic [1:0]     tx_idx_q, tx_idx_d;
  logic [31:0]    word_q, word_d;
  logic [31:0]    res_q, res_d;
  logic           rx_pulse_q, rx_pulse_d;
  logic           rx_drop_q, rx_drop_d;
  logic           timeout_q, timeout_d;
  logic           last_load;

  // Pulse cycle of the final operand word: the FSM leaves S_RX here, so a byte now is dropped.
  assign last_load = (state_q == StRx) && rx_pulse_q && (word_cnt_q == LastWord);

  // State register
  always_ff @(posedge i_Clk or negedge i_Rstn) begin
    if (!i_Rstn) begin
      state_q <= StRx;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRx:     if (last_load) state_d = StWait;
      StWait: begin
        if (i_core_busy) begin
          state_d = StRun;
        end else if (wait_cnt_q == LastWait) begin
          state_d = StRx;
        end
      end
      StRun:    if (!i_core_busy) state_d = StSettle;
      StSettle: if (settle_q) state_d = StTx;
      StTx:     if (i_tx_ready && (tx_idx_q == 2'd3)) state_d = StStep;
      StStep:   state_d = (res_cnt_q == LastRes) ? StRx : StSettle;
      default:  state_d = StRx;
    endcase
  end

  // Datapath next-state
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    wait_cnt_d = '0;
    res_cnt_d  = res_cnt_q;
    settle_d   = 1'b0;
    tx_idx_d   = tx_idx_q;
    word_d     = word_q;
    res_d      = res_q;
    rx_pulse_d = 1'b0;
    rx_drop_d  = rx_drop_q;
    timeout_d  = timeout_q;

    if (i_rx_valid) begin
      if ((state_q == StRx) && !last_load) begin
        word_d[{byte_cnt_q, 3'b000} +: 8] = i_rx_data;
        byte_cnt_d = byte_cnt_q + 2'd1;
        rx_pulse_d = (byte_cnt_q == 2'd3);
      end else begin
        rx_drop_d = 1'b1;
      end
    end

    if (rx_pulse_q) begin
      word_cnt_d = word_cnt_q + WcW'(1);
    end
    if (last_load) begin
      word_cnt_d = '0;
      byte_cnt_d = '0;
    end

    if (state_q == StWait) begin
      wait_cnt_d = wait_cnt_q + ToW'(1);
      if (!i_core_busy && (wait_cnt_q == LastWait)) begin
        timeout_d = 1'b1;
      end
    end

    // Two cycles in S_SETTLE let the core's registered RAM read catch up with its index.
    if (state_q == StSettle) begin
      settle_d = ~settle_q;
      if (settle_q) begin
        res_d    = i_core_result;
        tx_idx_d = '0;
      end
    end

    if ((state_q == StTx) && i_tx_ready) begin
      tx_idx_d = tx_idx_q + 2'd1;
    end

    if (state_q == StStep) begin
      res_cnt_d = (res_cnt_q == LastRes) ? '0 : res_cnt_q + RcW'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rstn) begin
    if (!i_Rstn) begin
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      wait_cnt_q <= '0;
      res_cnt_q  <= '0;
      settle_q   <= 1'b0;
      tx_idx_q   <= '0;
      word_q     <= '0;
      res_q      <= '0;
      rx_pulse_q <= 1'b0;
      rx_drop_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      res_cnt_q  <= res_cnt_d;
      settle_q   <= settle_d;
      tx_idx_q   <= tx_idx_d;
      word_q     <= word_d;
      res_q      <= res_d;
      rx_pulse_q <= rx_pulse_d;
      rx_drop_q  <= rx_drop_d;
      timeout_q  <= timeout_d;
    end
  end

  // Outputs
  always_comb begin
    o_state      = state_q;
    o_tx_valid   = (state_q == StTx);
    o_tx_data    = res_q[{tx_idx_q, 3'b000} +: 8];
    o_word       = word_q;
    o_word_ready = rx_pulse_q || (state_q == StStep);
    o_rx_drop    = rx_drop_q;
    o_timeout    = timeout_q;
  end

endmodule

// File: tb/tb_matrix_link_ctrl.sv
// Randomized bench for matrix_link_ctrl with a behavioural matrix-core model and
// expected word/byte streams derived directly from the job data.
module tb_matrix_link_ctrl;

  localparam int unsigned NIn    = 8;
  localparam int unsigned NOut   = 4;
  localparam int unsigned BusyTo = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_ready = 1'b1;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic [31:0] o_word;
  logic        o_word_ready;
  logic        core_busy;
  logic [31:0] core_result;
  logic [2:0]  o_state;
  logic        o_rx_drop;
  logic        o_timeout;

  always #5 clk = ~clk;

  matrix_link_ctrl #(
    .N_IN    (NIn),
    .N_OUT   (NOut),
    .BUSY_TO (BusyTo)
  ) dut (
    .i_Clk         (clk),
    .i_Rstn        (rstn),
    .i_rx_valid    (rx_valid),
    .i_rx_data     (rx_data),
    .o_tx_valid    (o_tx_valid),
    .o_tx_data     (o_tx_data),
    .i_tx_ready    (tx_ready),
    .o_word        (o_word),
    .o_word_ready  (o_word_ready),
    .i_core_busy   (core_busy),
    .i_core_result (core_result),
    .o_state       (o_state),
    .o_rx_drop     (o_rx_drop),
    .o_timeout     (o_timeout)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Job data shared by the core model and the expectations
  logic [7:0]  job_bytes [32];
  logic [31:0] res_vals  [NOut];
  bit          core_no_busy = 1'b0;

  // Core model: index-addressed RAM with a registered read, busy window after the last load
  logic [31:0] mem [NIn + NOut];
  int          idx, dly, busy_left;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx         <= 0;
      dly         <= 0;
      busy_left   <= 0;
      core_busy   <= 1'b0;
      core_result <= '0;
    end else begin
      core_result <= mem[idx];
      if (o_word_ready) begin
        if (idx < NIn) mem[idx] <= o_word;
        if (idx == NIn - 1 && !core_no_busy) dly <= 1;
        idx <= (idx == NIn + NOut - 1) ? 0 : idx + 1;
      end
      if (dly == 1) begin
        dly       <= 0;
        core_busy <= 1'b1;
        busy_left <= 50;
        for (int i = 0; i < NOut; i++) mem[NIn + i] <= res_vals[i];
      end else if (busy_left > 0) begin
        busy_left <= busy_left - 1;
        if (busy_left == 1) core_busy <= 1'b0;
      end
    end
  end

  // Monitor, sampling on the falling edge
  logic [31:0] pulse_q [$];
  logic [7:0]  tx_q [$];
  int          wait_cycles = 0, stall_cycles = 0, spacing_err = 0, stall_err = 0;
  bit          prev_pulse = 1'b0, prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_pulse = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (o_word_ready) begin
        pulse_q.push_back(o_word);
        if (prev_pulse) spacing_err++;
      end
      prev_pulse = o_word_ready;
      if (prev_stall && !(o_tx_valid && o_tx_data == prev_data)) stall_err++;
      if (o_tx_valid && !tx_ready) stall_cycles++;
      prev_stall = o_tx_valid && !tx_ready;
      prev_data  = o_tx_data;
      if (o_tx_valid && tx_ready) tx_q.push_back(o_tx_data);
      if (o_state == 3'd1) wait_cycles++;
    end
  end

  // Transmitter readiness: 0 always ready, 1 random, 2 one 20-cycle stall after two bytes
  int tx_policy = 0;
  int stall_left = 0;
  bit stall_done = 1'b0;

  always begin
    @(posedge clk);
    #1;
    case (tx_policy)
      0: tx_ready = 1'b1;
      1: tx_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (stall_left > 0) begin
          tx_ready = 1'b0;
          stall_left--;
        end else if (!stall_done && tx_q.size() == 2) begin
          stall_done = 1'b1;
          stall_left = 19;
          tx_ready   = 1'b0;
        end else begin
          tx_ready = 1'b1;
        end
      end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (o_state !== s && n < budget) begin
      tick();
      n++;
    end
    check(tag, o_state, s);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) job_bytes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < NOut; i++) res_vals[i] = $urandom;
  endtask

  task automatic start_job(input bit extra_byte);
    pulse_q.delete();
    tx_q.delete();
    wait_cycles  = 0;
    stall_cycles = 0;
    for (int i = 0; i < 32; i++) begin
      send_byte(job_bytes[i]);
      if (i != 31) repeat ($urandom_range(0, 2)) tick();
    end
    if (extra_byte) send_byte(8'hA5);
  endtask

  function automatic logic [31:0] load_word(input int w);
    return {job_bytes[4*w+3], job_bytes[4*w+2], job_bytes[4*w+1], job_bytes[4*w]};
  endfunction

  task automatic verify_job(input string tag);
    check({tag, "_npulse"}, pulse_q.size(), NIn + NOut);
    for (int i = 0; i < NIn + NOut && i < pulse_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), pulse_q[i], load_word(i < NIn ? i : NIn - 1));
    check({tag, "_ntx"}, tx_q.size(), 4 * NOut);
    for (int j = 0; j < 4 * NOut && j < tx_q.size(); j++)
      check($sformatf("%s_tx%0d", tag, j), tx_q[j], (res_vals[j/4] >> (8 * (j % 4))) & 32'hFF);
  endtask

  task automatic do_reset(input string tag);
    #3;
    rstn = 1'b0;
    #1;
    check({tag, "_state"}, o_state, 3'd0);
    check({tag, "_outs"}, {o_word, o_word_ready, o_tx_valid, o_tx_data, o_rx_drop, o_timeout}, '0);
    #10;
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    // Reset values
    #23;
    check("rst_state", o_state, 3'd0);
    check("rst_outs", {o_word, o_word_ready, o_tx_valid, o_tx_data, o_rx_drop, o_timeout}, '0);
    rstn = 1'b1;
    tick();

    // Job A: fixed bytes and results, one long transmitter stall
    for (int i = 0; i < 32; i++) job_bytes[i] = 8'(i + 1);
    res_vals[0] = 32'h11223344;
    res_vals[1] = 32'h55667788;
    res_vals[2] = 32'hDEADBEEF;
    res_vals[3] = 32'h00000000;
    tx_policy  = 2;
    stall_done = 1'b0;
    start_job(1'b0);
    wait_state(3'd1, 10, "a_enter_wait");
    check("a_word0", (pulse_q.size() > 0) ? pulse_q[0] : 32'hx, 32'h04030201);
    check("a_word7", (pulse_q.size() > 7) ? pulse_q[7] : 32'hx, 32'h201F1E1D);
    wait_state(3'd0, 2000, "a_done");
    verify_job("a");
    check("a_stall_seen", stall_cycles >= 20, 1);
    check("a_drop", o_rx_drop, 1'b0);
    check("a_timeout", o_timeout, 1'b0);

    // Job B: random data, a byte arrives while the core runs
    fill_random();
    tx_policy = 1;
    start_job(1'b0);
    wait_state(3'd1, 10, "b_enter_wait");
    wait_state(3'd2, 20, "b_enter_run");
    send_byte(8'($urandom_range(0, 255)));
    wait_state(3'd0, 2000, "b_done");
    verify_job("b");
    check("b_drop", o_rx_drop, 1'b1);

    // Job C: next job still assembles correctly
    fill_random();
    start_job(1'b0);
    wait_state(3'd1, 10, "c_enter_wait");
    wait_state(3'd0, 2000, "c_done");
    verify_job("c");
    check("c_timeout", o_timeout, 1'b0);

    // Timeout: busy never rises
    core_no_busy = 1'b1;
    fill_random();
    start_job(1'b0);
    wait_state(3'd1, 10, "to_enter_wait");
    wait_state(3'd0, 100, "to_back_rx");
    check("to_wait_cycles", wait_cycles, BusyTo);
    check("to_flag", o_timeout, 1'b1);
    check("to_ntx", tx_q.size(), 0);
    check("to_npulse", pulse_q.size(), NIn);
    core_no_busy = 1'b0;

    // Reset, then abort a job mid-transmit
    do_reset("rst_idle");
    fill_random();
    start_job(1'b0);
    wait_state(3'd4, 200, "d_enter_tx");
    begin
      int n = 0;
      while (!(o_state == 3'd4 && tx_q.size() >= 5) && n < 500) begin
        tick();
        n++;
      end
      check("d_mid_tx", (o_state == 3'd4) && (tx_q.size() >= 5), 1);
    end
    do_reset("rst_mid_tx");

    // Job E: byte coincides with the final load pulse
    fill_random();
    start_job(1'b1);
    wait_state(3'd1, 10, "e_enter_wait");
    wait_state(3'd0, 2000, "e_done");
    verify_job("e");
    check("e_drop", o_rx_drop, 1'b1);
    check("e_timeout", o_timeout, 1'b0);

    check("pulse_spacing", spacing_err, 0);
    check("tx_hold", stall_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
